// File: rtl/imem_arb_pkg.sv
// Shared types and sizing helpers for the instruction-memory arbiter.
// Owner encoding tracks which requester receives next cycle's response.
package imem_arb_pkg;

   localparam int DATA_W   = 32;
   // Wide enough for any STARVE_MAX in 1..15.
   localparam int STARVE_W = 4;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_LOAD  = 2'd2
   } owner_t;

   function automatic int idx_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/imem_arb_if.sv
// Bundles the fetch port, loader port and RAM port of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface imem_arb_if #(
   parameter int DEPTH = 32
);
   import imem_arb_pkg::*;

   localparam int AW = idx_w(DEPTH);

   logic              f_valid;
   logic [DATA_W-1:0] f_addr;
   logic              f_ready;
   logic              f_rvalid;
   logic [DATA_W-1:0] f_rdata;
   logic              f_err;

   logic              l_valid;
   logic              l_we;
   logic [DATA_W-1:0] l_addr;
   logic [DATA_W-1:0] l_wdata;
   logic              l_ready;
   logic              l_rvalid;
   logic [DATA_W-1:0] l_rdata;
   logic              l_err;

   logic              m_en;
   logic              m_we;
   logic [AW-1:0]     m_waddr;
   logic [DATA_W-1:0] m_wdata;
   logic [DATA_W-1:0] m_rdata;

   modport slave (
      input  f_valid, f_addr, l_valid, l_we, l_addr, l_wdata, m_rdata,
      output f_ready, f_rvalid, f_rdata, f_err,
             l_ready, l_rvalid, l_rdata, l_err,
             m_en, m_we, m_waddr, m_wdata
   );

   modport master (
      output f_valid, f_addr, l_valid, l_we, l_addr, l_wdata, m_rdata,
      input  f_ready, f_rvalid, f_rdata, f_err,
             l_ready, l_rvalid, l_rdata, l_err,
             m_en, m_we, m_waddr, m_wdata
   );

endinterface

// File: rtl/imem_arb_starve.sv
// Saturating count of consecutive cycles the loader has lost to fetch.
// starve_hit forces the next loader grant once the limit is reached.
module imem_arb_starve
   import imem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic starve_hit
);

   logic [STARVE_W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != STARVE_W'(STARVE_MAX))) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign starve_hit = (cnt == STARVE_W'(STARVE_MAX));

endmodule

// File: rtl/imem_arbiter.sv
// Fixed-priority arbiter sharing one synchronous-read instruction RAM between
// fetch and loader, with starvation relief and alignment/range checking.
module imem_arbiter
   import imem_arb_pkg::*;
#(
   parameter int DEPTH      = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic       clk,
   input  logic       rst,
   imem_arb_if.slave  bus
);

   localparam int AW = idx_w(DEPTH);

   logic              grant_f, grant_l, granted, legal, starve_hit;
   logic [DATA_W-1:0] req_addr;
   owner_t            owner_q, owner_d;
   logic              err_q, err_d;
   logic              zero_q, zero_d;

   imem_arb_starve #(.STARVE_MAX(STARVE_MAX)) u_starve (
      .clk        (clk),
      .rst        (rst),
      .inc        (bus.l_valid && bus.f_valid && grant_f),
      .clr        (grant_l || !bus.l_valid),
      .starve_hit (starve_hit)
   );

   // Grants are masked during reset so every output reads 0 while rst is high.
   always_comb begin
      grant_l  = !rst && bus.l_valid && (!bus.f_valid || starve_hit);
      grant_f  = !rst && bus.f_valid && !grant_l;
      granted  = grant_f || grant_l;
      req_addr = grant_l ? bus.l_addr : bus.f_addr;
      legal    = (req_addr[1:0] == 2'b00) &&
                 ({2'b00, req_addr[31:2]} < 32'(DEPTH));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q <= OWN_NONE;
         err_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         owner_q <= owner_d;
         err_q   <= err_d;
         zero_q  <= zero_d;
      end
   end

   // NOTE: defaults first in every combinational block keep it latch-free.
   always_comb begin
      owner_d = OWN_NONE;
      err_d   = 1'b0;
      zero_d  = 1'b0;
      if (grant_l) begin
         owner_d = OWN_LOAD;
      end else if (grant_f) begin
         owner_d = OWN_FETCH;
      end
      if (granted) begin
         err_d  = !legal;
         zero_d = !legal || (grant_l && bus.l_we);
      end
   end

   // Rejected requests never reach the RAM; write ack and errors return zero data.
   always_comb begin
      bus.f_ready  = grant_f;
      bus.l_ready  = grant_l;
      bus.m_en     = granted && legal;
      bus.m_we     = bus.m_en && grant_l && bus.l_we;
      bus.m_waddr  = bus.m_en ? req_addr[AW+1:2] : '0;
      bus.m_wdata  = bus.m_we ? bus.l_wdata : '0;
      bus.f_rvalid = (owner_q == OWN_FETCH);
      bus.l_rvalid = (owner_q == OWN_LOAD);
      bus.f_err    = bus.f_rvalid && err_q;
      bus.l_err    = bus.l_rvalid && err_q;
      bus.f_rdata  = (bus.f_rvalid && !zero_q) ? bus.m_rdata : '0;
      bus.l_rdata  = (bus.l_rvalid && !zero_q) ? bus.m_rdata : '0;
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed and randomized bench for imem_arbiter against a transaction-level
// model: a word array for memory contents and a denial count for fairness.
module tb_imem_arbiter;

   localparam int DEPTH      = 32;
   localparam int STARVE_MAX = 4;

   logic clk = 1'b0;
   logic rst;

   imem_arb_if #(.DEPTH(DEPTH)) bus ();

   imem_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM with a preload path used while the DUT is in reset.
   logic [31:0] mem [DEPTH];
   logic        pl_en;
   int          pl_idx;
   logic [31:0] pl_data;

   always @(posedge clk) begin
      if (pl_en) begin
         mem[pl_idx] <= pl_data;
      end else if (bus.m_en) begin
         if (bus.m_we) mem[bus.m_waddr] <= bus.m_wdata;
         bus.m_rdata <= mem[bus.m_waddr];
      end
   end

   // Reference model state.
   logic [31:0] ref_mem [DEPTH];
   int          deny;
   logic        exp_fv, exp_lv, exp_err;
   logic [31:0] exp_data;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, ".f_ready"},  32'(bus.f_ready),  32'd0);
      check({tag, ".l_ready"},  32'(bus.l_ready),  32'd0);
      check({tag, ".f_rvalid"}, 32'(bus.f_rvalid), 32'd0);
      check({tag, ".l_rvalid"}, 32'(bus.l_rvalid), 32'd0);
      check({tag, ".f_err"},    32'(bus.f_err),    32'd0);
      check({tag, ".l_err"},    32'(bus.l_err),    32'd0);
      check({tag, ".f_rdata"},  bus.f_rdata,       32'd0);
      check({tag, ".l_rdata"},  bus.l_rdata,       32'd0);
      check({tag, ".m_en"},     32'(bus.m_en),     32'd0);
      check({tag, ".m_we"},     32'(bus.m_we),     32'd0);
      check({tag, ".m_waddr"},  32'(bus.m_waddr),  32'd0);
      check({tag, ".m_wdata"},  bus.m_wdata,       32'd0);
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) return ($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(1, 3);
      if (r == 1) return (DEPTH + $urandom_range(0, 1000)) << 2;
      return $urandom_range(0, DEPTH - 1) << 2;
   endfunction

   // One clock: drive, compare against the model, advance the model.
   task automatic step(input string tag,
                       input logic fv, input logic [31:0] fa,
                       input logic lv, input logic lwe,
                       input logic [31:0] la, input logic [31:0] ld,
                       output logic gf, output logic gl);
      logic [31:0] a;
      logic        legal, any;
      int          idx;
      bus.f_valid = fv;
      bus.f_addr  = fa;
      bus.l_valid = lv;
      bus.l_we    = lwe;
      bus.l_addr  = la;
      bus.l_wdata = ld;
      #3;
      gl    = lv && (!fv || deny == STARVE_MAX);
      gf    = fv && !gl;
      any   = gf || gl;
      a     = gl ? la : fa;
      legal = (a % 4 == 0) && ((a / 4) < DEPTH);
      idx   = int'(a / 4);

      check({tag, ".f_ready"}, 32'(bus.f_ready), 32'(gf));
      check({tag, ".l_ready"}, 32'(bus.l_ready), 32'(gl));
      check({tag, ".m_en"},    32'(bus.m_en),    32'(any && legal));
      check({tag, ".m_we"},    32'(bus.m_we),    32'(gl && lwe && legal));
      if (any && legal) check({tag, ".m_waddr"}, 32'(bus.m_waddr), a / 4);
      if (gl && lwe && legal) check({tag, ".m_wdata"}, bus.m_wdata, ld);

      check({tag, ".f_rvalid"}, 32'(bus.f_rvalid), 32'(exp_fv));
      check({tag, ".l_rvalid"}, 32'(bus.l_rvalid), 32'(exp_lv));
      check({tag, ".f_err"},    32'(bus.f_err),    32'(exp_fv && exp_err));
      check({tag, ".l_err"},    32'(bus.l_err),    32'(exp_lv && exp_err));
      check({tag, ".f_rdata"},  bus.f_rdata,       exp_fv ? exp_data : 32'd0);
      check({tag, ".l_rdata"},  bus.l_rdata,       exp_lv ? exp_data : 32'd0);

      exp_fv   = gf;
      exp_lv   = gl;
      exp_err  = any && !legal;
      exp_data = (any && legal && !(gl && lwe)) ? ref_mem[idx] : 32'd0;
      if (gl && lwe && legal) ref_mem[idx] = ld;
      if (lv && fv && gf) begin
         if (deny < STARVE_MAX) deny++;
      end else if (gl || !lv) begin
         deny = 0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic        gf, gl;
      logic        pfv, plv, plwe;
      logic [31:0] pfa, pla, pld;
      int          f_grants;

      rst         = 1'b1;
      pl_en       = 1'b0;
      pl_idx      = 0;
      pl_data     = '0;
      bus.f_valid = 1'b0;
      bus.f_addr  = '0;
      bus.l_valid = 1'b0;
      bus.l_we    = 1'b0;
      bus.l_addr  = '0;
      bus.l_wdata = '0;
      deny        = 0;
      exp_fv      = 1'b0;
      exp_lv      = 1'b0;
      exp_err     = 1'b0;
      exp_data    = '0;

      #1;
      check_quiet("reset");
      for (int i = 0; i < DEPTH; i++) begin
         pl_en   = 1'b1;
         pl_idx  = i;
         pl_data = (i < 3) ? 32'h11 * (i + 1) : $urandom;
         ref_mem[i] = pl_data;
         @(posedge clk);
         #1;
      end
      pl_en = 1'b0;
      bus.f_valid = 1'b1;
      bus.l_valid = 1'b1;
      #1;
      check_quiet("reset_valid_held");
      rst = 1'b0;

      step("idle", 0, 0, 0, 0, 0, 0, gf, gl);

      // Back-to-back fetches of preloaded words.
      for (int i = 0; i < 3; i++) step("fetch_seq", 1, 32'(i * 4), 0, 0, 0, 0, gf, gl);
      step("fetch_seq_tail", 0, 0, 0, 0, 0, 0, gf, gl);

      // Loader write then fetch of the same word.
      step("ld_write", 0, 0, 1, 1, 32'h10, 32'hDEADBEEF, gf, gl);
      step("fetch_after_wr", 1, 32'h10, 0, 0, 0, 0, gf, gl);
      step("fetch_after_wr_tail", 0, 0, 0, 0, 0, 0, gf, gl);

      // Contention: loader must win every STARVE_MAX+1 cycles.
      f_grants = 0;
      for (int i = 0; i < 3 * (STARVE_MAX + 1); i++) begin
         step("contend", 1, 32'($urandom_range(0, DEPTH - 1) * 4),
              1, 0, 32'h8, 0, gf, gl);
         if (gf) f_grants++;
      end
      check("contend.fetch_grants", 32'(f_grants), 32'(3 * STARVE_MAX));
      step("contend_tail", 0, 0, 0, 0, 0, 0, gf, gl);

      // Misaligned fetch and out-of-range loader write.
      step("bad_fetch", 1, 32'h6, 0, 0, 0, 0, gf, gl);
      step("bad_load", 0, 0, 1, 1, 32'(4 * DEPTH), 32'hCAFEF00D, gf, gl);
      step("bad_tail", 0, 0, 0, 0, 0, 0, gf, gl);
      step("bad_verify", 0, 0, 1, 0, 32'h0, 0, gf, gl);
      step("bad_verify_tail", 0, 0, 0, 0, 0, 0, gf, gl);

      // Reset while a fetch response is pending.
      step("pre_reset_fetch", 1, 32'h4, 0, 0, 0, 0, gf, gl);
      rst = 1'b1;
      #1;
      check_quiet("mid_reset");
      @(posedge clk);
      #1;
      rst    = 1'b0;
      exp_fv = 1'b0;
      exp_lv = 1'b0;
      deny   = 0;
      step("post_reset_idle", 0, 0, 0, 0, 0, 0, gf, gl);
      f_grants = 0;
      for (int i = 0; i < STARVE_MAX + 1; i++) begin
         step("post_reset_contend", 1, 32'h0, 1, 0, 32'h4, 0, gf, gl);
         if (gf) f_grants++;
      end
      check("post_reset.fetch_grants", 32'(f_grants), 32'(STARVE_MAX));
      step("post_reset_tail", 0, 0, 0, 0, 0, 0, gf, gl);

      // Alternating single-cycle requests.
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0)
            step("alt_f", 1, 32'($urandom_range(0, DEPTH - 1) * 4), 0, 0, 0, 0, gf, gl);
         else
            step("alt_l", 0, 0, 1, 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, DEPTH - 1) * 4), $urandom, gf, gl);
      end

      // Random traffic; a request holds its payload until accepted.
      pfv = 1'b0; plv = 1'b0; plwe = 1'b0;
      pfa = '0; pla = '0; pld = '0;
      gf  = 1'b1; gl = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (!pfv || gf) begin
            pfv = ($urandom_range(0, 3) != 0);
            pfa = rand_addr();
         end
         if (!plv || gl) begin
            plv  = ($urandom_range(0, 2) != 0);
            plwe = 1'($urandom_range(0, 1));
            pla  = rand_addr();
            pld  = $urandom;
         end
         step("rand", pfv, pfa, plv, plwe, pla, pld, gf, gl);
      end
      step("rand_tail", 0, 0, 0, 0, 0, 0, gf, gl);

      // Read back every word through the loader to confirm memory contents.
      for (int i = 0; i < DEPTH; i++) step("readback", 0, 0, 1, 0, 32'(i * 4), 0, gf, gl);
      step("readback_tail", 0, 0, 0, 0, 0, 0, gf, gl);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares one single-port, word-addressed instruction memory between two requesters:
  - port 0: instruction fetch, read-only.
  - port 1: program loader/debug, read and write.
- Sits between the fetch stage, the loader and a synchronous-read instruction RAM with 1-cycle read latency.
- Fetch has fixed priority. A starvation counter guarantees the loader forward progress.
- Adds alignment and range checking, and returns an error response instead of aliasing.

Parameters:
- DEPTH, 32, memory depth in 32-bit words (power of two, ≥2).
- STARVE_MAX, 4, consecutive cycles the loader may be denied before it is forced a grant (1..15).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- f_valid  in  1  fetch request valid.
- f_addr  in  32  fetch byte address.
- f_ready  out  1  fetch request accepted this cycle.
- f_rvalid  out  1  fetch response valid.
- f_rdata  out  32  fetch read data.
- f_err  out  1  fetch response error (misaligned or out of range).
- l_valid  in  1  loader request valid.
- l_we  in  1  loader write enable.
- l_addr  in  32  loader byte address.
- l_wdata  in  32  loader write data.
- l_ready  out  1  loader request accepted.
- l_rvalid  out  1  loader response valid (reads and writes).
- l_rdata  out  32  loader read data.
- l_err  out  1  loader response error.
- m_en  out  1  memory access enable.
- m_we  out  1  memory write enable.
- m_waddr  out  $clog2(DEPTH)  memory word index.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data, valid the cycle after m_en.

Behaviour:
- Reset, asynchronous: all outputs 0; owner register = NONE; starvation counter = 0; error-pending flag = 0.
- Handshake:
  - A request transfers when valid && ready.
  - A requester must hold valid and its payload stable until ready.
  - Ready is combinational from the valid signals and the starvation counter. No wait on responses: accepts back-to-back, one grant per cycle.
- Grant rule, each cycle:
  - Loader is granted if l_valid and (!f_valid or starve_cnt == STARVE_MAX).
  - Otherwise fetch is granted if f_valid.
  - At most one of f_ready/l_ready is high.
- Starvation counter:
  - Increments when l_valid && f_valid && fetch granted.
  - Clears to 0 on any loader grant, or when l_valid is low.
  - Saturates at STARVE_MAX.
- Legality check on the granted request:
  - addr[1:0] != 0, or addr[31:2] ≥ DEPTH, is illegal.
  - Illegal requests are accepted but do not assert m_en; no write occurs.
  - The response comes next cycle with err=1 and rdata=0.
- Legal grant: m_en=1, m_we = l_we (0 for fetch), m_waddr = addr[$clog2(DEPTH)+1:2], m_wdata = l_wdata. All of these are combinational in the grant cycle.
- Response, one cycle after acceptance, fixed latency 1:
  - The owner register (NONE/FETCH/LOAD) and the error flag are registered at acceptance.
  - Next cycle, the owner's rvalid=1 for exactly one cycle; rdata = m_rdata (0 if err or write); err = registered flag.
  - The other port's rvalid=0.
  - When no grant occurs, owner becomes NONE.
- Loader writes also produce an l_rvalid acknowledge with l_rdata=0.
- Simultaneous events:
  - A response for request N and acceptance of request N+1 occur in the same cycle.
  - The owner register updates to N+1's owner at the same edge the N response ends.
- Reset mid-operation: a pending response is dropped (no rvalid after reset release). An in-flight write that was in its grant cycle at the reset edge is not guaranteed.
- Responses are not backpressured. Requesters must be able to take a response every cycle.

Decomposition:
- Package imem_arb_pkg:
  - typedef enum logic [1:0] owner_t {OWN_NONE, OWN_FETCH, OWN_LOAD}.
  - Localparam for the word-index width helper.
- One sub-module, imem_arb_starve: the saturating starvation counter. Outputs starve_hit.
- Top module holds grant logic, the legality check and the response routing registers.

Test Plan:
- Fetch only, f_addr=0x0,0x4,0x8 back-to-back with memory preloaded 0x11,0x22,0x33 → f_ready=1 each cycle; f_rvalid on cycles 1–3 with f_rdata 0x11,0x22,0x33; m_we never 1.
- Loader write l_addr=0x10 wdata=0xDEADBEEF, then fetch 0x10 → write ack with l_rvalid=1, l_err=0; fetch returns 0xDEADBEEF.
- f_valid and l_valid held high continuously, STARVE_MAX=4 → fetch granted 4 cycles, loader granted on the 5th, pattern repeats; never both ready.
- Fetch f_addr=0x6 and loader l_addr=4*DEPTH → m_en=0 both cycles; f_err=1 and l_err=1 with rdata=0 the following cycles.
- Assert rst for 1 cycle in the cycle after a fetch is accepted → all outputs 0 immediately; no f_rvalid after release; starve_cnt=0.
- Alternating f_valid/l_valid single-cycle requests → each granted immediately; responses routed to the correct port with no cross-talk.
